// File: rtl/mux4_1_rr_arb.sv
// 4:1 round-robin arbitrating mux into a single registered output slot; 1 clk input-to-output latency.
// Backpressure: in_ready only toward the granted channel and only while the slot is free (empty or draining).
// Optional packet lock (hold grant until in_last) when MUX4_PKT_LOCK_EN is defined.
module mux4_1_rr_arb #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       in_valid,
    input  logic [WIDTH-1:0] in_data0,
    input  logic [WIDTH-1:0] in_data1,
    input  logic [WIDTH-1:0] in_data2,
    input  logic [WIDTH-1:0] in_data3,
    output logic [3:0]       in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_sel,
`ifdef MUX4_PKT_LOCK_EN
    input  logic [3:0]       in_last,
    output logic             out_last,
`endif
    input  logic             out_ready
);

    logic [1:0]       last_q;
    logic [3:0]       gnt_rr;
    logic [1:0]       rr_idx;
    logic             rr_found;
    logic [1:0]       cand;
    logic [3:0]       gnt;
    logic [1:0]       gnt_idx;
    logic [WIDTH-1:0] gnt_data;
    logic             slot_free;
    logic             xfer_in;

    // Rotating priority search starting just after the last granted channel.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = last_q;
        cand     = last_q;
        for (int k = 1; k <= 4; k++) begin
            cand = last_q + 2'(k);
            if (!rr_found && in_valid[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end
        gnt_rr = rr_found ? (4'b0001 << rr_idx) : 4'b0000;
    end

`ifdef MUX4_PKT_LOCK_EN
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t     state_q;
    logic [1:0] lock_q;
    logic       sel_last;

    // While locked the grant is pinned; an idle locked channel produces a bubble.
    always_comb begin
        if (state_q == LOCKED) begin
            gnt_idx = lock_q;
            gnt     = in_valid[lock_q] ? (4'b0001 << lock_q) : 4'b0000;
        end else begin
            gnt_idx = rr_idx;
            gnt     = gnt_rr;
        end
    end

    assign sel_last = in_last[gnt_idx];
`else
    assign gnt_idx = rr_idx;
    assign gnt     = gnt_rr;
`endif

    always_comb begin
        case (gnt_idx)
            2'd0:    gnt_data = in_data0;
            2'd1:    gnt_data = in_data1;
            2'd2:    gnt_data = in_data2;
            default: gnt_data = in_data3;
        endcase
    end

    // rst_n gating keeps ready low for the whole reset window.
    assign slot_free = ~out_valid | out_ready;
    assign in_ready  = gnt & {4{slot_free & rst_n}};
    assign xfer_in   = |in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= 2'b00;
            last_q    <= 2'd3;
`ifdef MUX4_PKT_LOCK_EN
            out_last  <= 1'b0;
            state_q   <= IDLE;
            lock_q    <= 2'd0;
`endif
        end else if (xfer_in) begin
            out_valid <= 1'b1;
            out_data  <= gnt_data;
            out_sel   <= gnt_idx;
`ifdef MUX4_PKT_LOCK_EN
            out_last  <= sel_last;
            if (state_q == IDLE) begin
                if (!sel_last) begin
                    state_q <= LOCKED;
                    lock_q  <= gnt_idx;
                end else begin
                    last_q  <= gnt_idx;
                end
            end else if (sel_last) begin
                state_q <= IDLE;
                last_q  <= gnt_idx;
            end
`else
            last_q    <= gnt_idx;
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
